// File: rtl/memory_access_unit_pkg.sv
// memory_access_unit_pkg
//   Shared ISA constants and helpers for the MEM-stage load/store unit:
//   - MIPS load/store opcodes and instruction field extractors
//   - access-size codes and LSU FSM state encodings
//   - opcode decoder returning access size and direction
package memory_access_unit_pkg;

   localparam logic [5:0] OPC_LB  = 6'h20;
   localparam logic [5:0] OPC_LH  = 6'h21;
   localparam logic [5:0] OPC_LW  = 6'h23;
   localparam logic [5:0] OPC_LBU = 6'h24;
   localparam logic [5:0] OPC_LHU = 6'h25;
   localparam logic [5:0] OPC_SB  = 6'h28;
   localparam logic [5:0] OPC_SH  = 6'h29;
   localparam logic [5:0] OPC_SW  = 6'h2B;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2
   } size_e;

   typedef enum logic [1:0] {
      LSU_IDLE    = 2'd0,
      LSU_REQUEST = 2'd1,
      LSU_DONE    = 2'd2
   } lsu_state_e;

   typedef struct packed {
      logic  is_mem;
      logic  is_store;
      size_e size;
   } mem_dec_t;

   function automatic logic [5:0] get_opc(input logic [31:0] instr);
      return instr[31:26];
   endfunction

   function automatic logic [4:0] get_rt(input logic [31:0] instr);
      return instr[20:16];
   endfunction

   function automatic mem_dec_t decode_mem(input logic [5:0] opc);
      mem_dec_t d;
      d = '{is_mem: 1'b1, is_store: 1'b0, size: SIZE_W};
      case (opc)
         OPC_LB, OPC_LBU: d.size = SIZE_B;
         OPC_LH, OPC_LHU: d.size = SIZE_H;
         OPC_LW:          d.size = SIZE_W;
         OPC_SB:          begin d.size = SIZE_B; d.is_store = 1'b1; end
         OPC_SH:          begin d.size = SIZE_H; d.is_store = 1'b1; end
         OPC_SW:          begin d.size = SIZE_W; d.is_store = 1'b1; end
         default:         d.is_mem = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/memory_access_unit_if.sv
// memory_access_unit_if
//   Word-wide valid/ready data-memory bus.
//   master (LSU): memReq, memWe, memAddr, memBe, memWData out; memReady, memRData in
//   slave (memory): the reverse
interface memory_access_unit_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  memReq;
   logic                  memWe;
   logic [ADDR_WIDTH-1:0] memAddr;
   logic [3:0]            memBe;
   logic [31:0]           memWData;
   logic                  memReady;
   logic [31:0]           memRData;

   modport master (
      output memReq, memWe, memAddr, memBe, memWData,
      input  memReady, memRData
   );

   modport slave (
      input  memReq, memWe, memAddr, memBe, memWData,
      output memReady, memRData
   );
endinterface

// File: rtl/memory_access_unit_lane_align.sv
// memory_access_unit_lane_align
//   Combinational byte-lane logic for one access.
//   i_size, i_offset        : access size and byte offset within the word
//   i_storeData, i_memRData : store operand and raw read word
//   o_memBe                 : byte lanes touched
//   o_wData                 : store data replicated across lanes
//   o_rData                 : read word shifted so the accessed bytes sit at bit 0
//   o_misaligned            : offset not a multiple of the access size
module memory_access_unit_lane_align
   import memory_access_unit_pkg::*;
(
   input  size_e       i_size,
   input  logic [1:0]  i_offset,
   input  logic [31:0] i_storeData,
   input  logic [31:0] i_memRData,
   output logic [3:0]  o_memBe,
   output logic [31:0] o_wData,
   output logic [31:0] o_rData,
   output logic        o_misaligned
);

   always_comb begin
      o_memBe      = 4'b1111;
      o_wData      = i_storeData;
      o_misaligned = 1'b0;
      case (i_size)
         SIZE_B: begin
            o_memBe = 4'b0001 << i_offset;
            o_wData = {4{i_storeData[7:0]}};
         end
         SIZE_H: begin
            o_memBe      = i_offset[1] ? 4'b1100 : 4'b0011;
            o_wData      = {2{i_storeData[15:0]}};
            o_misaligned = i_offset[0];
         end
         default: begin
            o_misaligned = |i_offset;
         end
      endcase
   end

   // Zeros shift in from the top; sign/zero extension happens downstream.
   assign o_rData = i_memRData >> {i_offset, 3'b000};

endmodule

// File: rtl/memory_access_unit.sv
// memory_access_unit
//   MEM-stage load/store unit: turns a load/store into one bus transaction
//   and stalls the pipeline until it completes.
//   clk, resetN  : clock, asynchronous active-low reset
//   issue        : valid instruction in MEM
//   instruction  : MEM-stage instruction (opcode decoded here)
//   aluOut       : effective address
//   storeData    : rt value for stores
//   bus          : data-memory bus (master side, outputs registered)
//   memoryOut    : right-aligned load data, held until the next load completes
//   stall        : freeze IF..MEM
//   done         : one-cycle pulse when an access finishes
//   addrError    : misaligned access seen in IDLE (combinational)
module memory_access_unit
   import memory_access_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic                  issue,
   input  logic [31:0]           instruction,
   input  logic [ADDR_WIDTH-1:0] aluOut,
   input  logic [31:0]           storeData,
   memory_access_unit_if.master  bus,
   output logic [31:0]           memoryOut,
   output logic                  stall,
   output logic                  done,
   output logic                  addrError
);

   lsu_state_e            r_state, w_nxt;
   logic                  r_memReq, r_memWe;
   logic [ADDR_WIDTH-1:0] r_memAddr;
   logic [3:0]            r_memBe;
   logic [31:0]           r_memWData, r_memoryOut;
   logic [1:0]            r_offset;
   size_e                 r_size;

   mem_dec_t              w_dec;
   logic                  w_memOp, w_mis, w_start, w_idle;
   size_e                 w_size;
   logic [1:0]            w_off;
   logic [3:0]            w_be;
   logic [31:0]           w_wData, w_rData;

   assign w_dec   = decode_mem(get_opc(instruction));
   assign w_memOp = issue && w_dec.is_mem;
   assign w_idle  = (r_state == LSU_IDLE);

   // In IDLE the lane logic looks at the incoming instruction; once captured
   // it works from the registered size/offset so later input changes are ignored.
   assign w_size  = w_idle ? w_dec.size  : r_size;
   assign w_off   = w_idle ? aluOut[1:0] : r_offset;
   assign w_start = w_memOp && !w_mis;

   memory_access_unit_lane_align u_lane (
      .i_size       (w_size),
      .i_offset     (w_off),
      .i_storeData  (storeData),
      .i_memRData   (bus.memRData),
      .o_memBe      (w_be),
      .o_wData      (w_wData),
      .o_rData      (w_rData),
      .o_misaligned (w_mis)
   );

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         LSU_IDLE:    if (w_start) w_nxt = LSU_REQUEST;
         LSU_REQUEST: if (r_memReq && bus.memReady) w_nxt = LSU_DONE;
         LSU_DONE:    w_nxt = LSU_IDLE;
         default:     w_nxt = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state     <= LSU_IDLE;
         r_memReq    <= 1'b0;
         r_memWe     <= 1'b0;
         r_memAddr   <= '0;
         r_memBe     <= '0;
         r_memWData  <= '0;
         r_memoryOut <= '0;
         r_offset    <= '0;
         r_size      <= SIZE_B;
      end else begin
         r_state <= w_nxt;
         case (r_state)
            LSU_IDLE: if (w_start) begin
               r_memReq   <= 1'b1;
               r_memWe    <= w_dec.is_store;
               r_memAddr  <= {aluOut[ADDR_WIDTH-1:2], 2'b00};
               r_memBe    <= w_be;
               r_memWData <= w_dec.is_store ? w_wData : 32'h0;
               r_offset   <= aluOut[1:0];
               r_size     <= w_dec.size;
            end
            LSU_REQUEST: if (r_memReq && bus.memReady) begin
               r_memReq <= 1'b0;
               if (!r_memWe) r_memoryOut <= w_rData;
            end
            default: ;
         endcase
      end
   end

   assign bus.memReq   = r_memReq;
   assign bus.memWe    = r_memWe;
   assign bus.memAddr  = r_memAddr;
   assign bus.memBe    = r_memBe;
   assign bus.memWData = r_memWData;
   assign memoryOut    = r_memoryOut;

   assign stall     = (w_idle && w_start) || (r_state == LSU_REQUEST);
   assign done      = (r_state == LSU_DONE);
   assign addrError = w_memOp && w_mis && w_idle;

   // Only the opcode is decoded here; the rest of the word is pipeline payload.
   logic w_unused;
   assign w_unused = &{1'b0, instruction[25:0]};

endmodule

// File: tb/tb_memory_access_unit.sv
module tb_memory_access_unit;
   import memory_access_unit_pkg::*;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        issue = 1'b0;
   logic [31:0] instruction = '0;
   logic [31:0] aluOut = '0;
   logic [31:0] storeData = '0;
   logic [31:0] memoryOut;
   logic        stall, done, addrError;

   memory_access_unit_if #(.ADDR_WIDTH(32)) bus();

   memory_access_unit #(.ADDR_WIDTH(32)) dut (
      .clk         (clk),
      .resetN      (resetN),
      .issue       (issue),
      .instruction (instruction),
      .aluOut      (aluOut),
      .storeData   (storeData),
      .bus         (bus),
      .memoryOut   (memoryOut),
      .stall       (stall),
      .done        (done),
      .addrError   (addrError)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_bad = 0;
   logic [31:0] m_out = '0;   // reference copy of memoryOut

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [5:0] opc);
      if (opc == OPC_LB || opc == OPC_LBU || opc == OPC_SB) return 1;
      if (opc == OPC_LH || opc == OPC_LHU || opc == OPC_SH) return 2;
      return 4;
   endfunction

   function automatic bit is_store(input logic [5:0] opc);
      return (opc == OPC_SB || opc == OPC_SH || opc == OPC_SW);
   endfunction

   // One access from the pipeline's point of view; dly = extra REQUEST cycles
   // before memReady is raised.
   task automatic do_access(input logic [5:0] opc, input logic [31:0] addr,
                            input logic [31:0] sd, input logic [31:0] rd, input int dly);
      int          n, off;
      bit          st, mis;
      logic [3:0]  be;
      logic [31:0] wd, r;
      n   = nbytes(opc);
      off = int'(addr[1:0]);
      mis = (off % n) != 0;
      st  = is_store(opc);
      be  = '0;
      for (int i = 0; i < 4; i++) if (i >= off && i < off + n) be[i] = 1'b1;
      wd  = '0;
      if (st) for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % n) +: 8];

      @(negedge clk);
      chk("idle_req", bus.memReq, 0);
      chk("idle_done", done, 0);
      r = $urandom;
      issue = 1'b1;
      instruction = {opc, r[25:0]};
      aluOut = addr;
      storeData = sd;
      bus.memReady = 1'(($urandom % 2));   // no request pending: must be ignored
      bus.memRData = $urandom;
      #1;
      chk("addrError", addrError, mis);
      chk("stall_idle", stall, !mis);

      if (mis) begin
         @(negedge clk);
         chk("mis_req", bus.memReq, 0);
         chk("mis_done", done, 0);
         chk("mis_stall", stall, 0);
         issue = 1'b0;
         return;
      end

      for (int k = 0; k <= dly; k++) begin
         @(negedge clk);
         chk("req", bus.memReq, 1);
         chk("addr", bus.memAddr, {addr[31:2], 2'b00});
         chk("be", bus.memBe, be);
         chk("we", bus.memWe, st);
         chk("wdata", bus.memWData, wd);
         chk("stall_req", stall, 1);
         chk("done_req", done, 0);
         // Inputs may change while the access is in flight.
         r = $urandom;
         issue = 1'(r[31]);
         instruction = $urandom;
         aluOut = $urandom;
         bus.memReady = (k == dly);
         bus.memRData = (k == dly) ? rd : $urandom;
      end

      @(negedge clk);
      chk("done", done, 1);
      chk("stall_done", stall, 0);
      chk("req_done", bus.memReq, 0);
      if (!st) m_out = rd >> (8 * off);
      chk("memoryOut", memoryOut, m_out);
      issue = 1'b0;
      bus.memReady = 1'(($urandom % 2));
   endtask

   logic [5:0] ops [8] = '{OPC_LB, OPC_LH, OPC_LW, OPC_LBU, OPC_LHU, OPC_SB, OPC_SH, OPC_SW};

   initial begin
      bus.memReady = 1'b0;
      bus.memRData = '0;
      #1;
      chk("rst_req", bus.memReq, 0);
      chk("rst_be", bus.memBe, 0);
      chk("rst_out", memoryOut, 0);
      chk("rst_stall", stall, 0);
      chk("rst_done", done, 0);
      repeat (2) @(negedge clk);
      resetN = 1'b1;

      // directed cases
      do_access(OPC_LW, 32'h1000_0008, 32'h0, 32'hDEAD_BEEF, 2);
      do_access(OPC_LB, 32'h1000_0003, 32'h0, 32'h8011_2233, 0);
      chk("lb_val", memoryOut, 32'h0000_0080);
      do_access(OPC_SH, 32'h2000_0002, 32'h1234_ABCD, 32'h5555_5555, 0);
      chk("sh_keep", memoryOut, 32'h0000_0080);
      do_access(OPC_LW, 32'h0000_0002, 32'h0, 32'h0, 0);

      // reset in the middle of a REQUEST
      @(negedge clk);
      issue = 1'b1;
      instruction = {OPC_LW, 26'h0};
      aluOut = 32'h100;
      bus.memReady = 1'b0;
      @(negedge clk);
      chk("pre_rst_req", bus.memReq, 1);
      issue = 1'b0;
      #2 resetN = 1'b0;
      #1;
      chk("arst_req", bus.memReq, 0);
      chk("arst_out", memoryOut, 0);
      chk("arst_done", done, 0);
      chk("arst_stall", stall, 0);
      chk("arst_addr", bus.memAddr, 0);
      m_out = '0;
      @(negedge clk);
      resetN = 1'b1;
      do_access(OPC_LW, 32'h4, 32'h0, 32'h5, 0);
      chk("post_rst", memoryOut, 32'h5);

      do_access(OPC_SB, 32'h3000_0001, 32'h0000_00AA, 32'h0, 0);
      do_access(OPC_LHU, 32'h3000_0002, 32'h0, 32'hBEEF_1234, 0);
      chk("lhu_val", memoryOut, 32'h0000_BEEF);

      // random traffic
      for (int t = 0; t < 60; t++) begin
         logic [31:0] a;
         a = $urandom;
         if (($urandom % 4) != 0) a[1:0] = 2'(($urandom % 4));
         do_access(ops[$urandom % 8], a, $urandom, $urandom, int'($urandom % 4));
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
